gate_bist_ctrl: RTL and testbench
=================================

GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter LOOPS, default 2: number of full 4-vector sweeps per run; legal range 1..8.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 abort  input  1  terminates a run; sampled in APPLY/SAMPLE.
REQ-007 a_out  output  1  stimulus to the XOR/XNOR gate unit input a.
REQ-008 b_out  output  1  stimulus to the XOR/XNOR gate unit input b.
REQ-009 xor_in  input  1  gate unit xor_out.
REQ-010 xnor_in  input  1  gate unit xnor_out.
REQ-011 busy  output  1  high while in APPLY or SAMPLE.
REQ-012 done  output  1  one-cycle pulse at normal run completion.
REQ-013 pass  output  1  high after a completed run with err_cnt==0; held until next accepted start.
REQ-014 err_cnt  output  4  count of failing vector checks, saturating at 15.
REQ-015 fail_vec  output  4  bit i set if vector i={a,b} failed at least once in the run.

Function
REQ-016 States SHALL be IDLE, APPLY, SAMPLE, DONE; all outputs registered.
REQ-017 IDLE: start=1 -> APPLY; err_cnt, fail_vec, pass cleared on the same edge; vector index and loop counter set to 0.
REQ-018 APPLY: {a_out,b_out} = vector index (order 00,01,10,11); always -> SAMPLE (one-cycle settle for the combinational gate unit).
REQ-019 SAMPLE: {a_out,b_out} held; expected xor=a^b, xnor=~(a^b); any mismatch on either input counts as ONE error: err_cnt+1 (saturating), fail_vec[index]=1.
REQ-020 SAMPLE with index<3 -> index+1, APPLY; index==3 and loop<LOOPS-1 -> index wraps to 0, loop+1, APPLY; index==3 and loop==LOOPS-1 -> DONE.
REQ-021 DONE: done=1 for exactly one cycle, pass=(err_cnt==0) including the final SAMPLE's result, busy=0 -> IDLE.
REQ-022 Latency: start accepted at edge 0 -> busy high for exactly 8*LOOPS cycles -> done high during cycle 8*LOOPS+1.
REQ-023 start while busy or in DONE SHALL be ignored (no restart, no counter clear).
REQ-024 abort=1 in APPLY/SAMPLE -> IDLE on the next edge: busy=0, no done, pass=0, a_out=b_out=0, err_cnt/fail_vec retain partial values; the aborted SAMPLE's compare is discarded.
REQ-025 abort and start asserted together in IDLE: start wins, abort ignored.
REQ-026 a_out=b_out=0 in IDLE and DONE.

Reset
REQ-027 rst=1 SHALL, on the next clk edge, force IDLE, a_out=b_out=busy=done=pass=0, err_cnt=0, fail_vec=0, counters 0, overriding start/abort.
REQ-028 rst mid-run SHALL discard the run with no done pulse; the next start SHALL run from vector 00.

Structure
REQ-029 Shared package gate_bist_pkg (Verilog include gate_bist_pkg.vh): state encodings, NUM_VEC=4, ERR_W=4, ERR_MAX=15.
REQ-030 Single module; no sub-module; the saturating error counter stays inline.

Verification
REQ-031 Fault-free gate unit, LOOPS=2, 1-cycle start -> busy 16 cycles, done pulse in cycle 17, pass=1, err_cnt=0, fail_vec=0000, stimulus sequence 00,01,10,11 twice.
REQ-032 xor_in stuck-at-0, xnor correct, LOOPS=2 -> err_cnt=4, fail_vec=0110, pass=0.
REQ-033 xnor_in tied to xor_out, LOOPS=2 -> err_cnt=8, fail_vec=1111, pass=0.
REQ-034 All vectors failing, LOOPS=5 -> 20 failing checks, err_cnt=15 (saturated), fail_vec=1111.
REQ-035 start re-pulsed at cycle 3 -> ignored, done still in cycle 17; abort at cycle 5 in a new run -> IDLE next edge, no done, pass=0, a_out=b_out=0.
REQ-036 rst asserted at cycle 6 of a run -> all outputs 0 next edge, no done; a following start yields a clean 16-cycle run with pass=1.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared state encoding and widths for the XOR/XNOR gate BIST controller
package gate_bist_pkg;
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
    localparam int NUM_VEC = 4;
    localparam int ERR_W = 4;
    localparam logic [ERR_W-1:0] ERR_MAX = 4'd15;
endpackage

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: sweeps all {a,b} vectors LOOPS times through an XOR/XNOR gate unit and logs failures
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int LOOPS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               a_out,
    output logic               b_out,
    input  logic               xor_in,
    input  logic               xnor_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [NUM_VEC-1:0] fail_vec
);
    state_t state;
    logic [1:0] idx;
    logic [2:0] loop_cnt;
    logic mis;
    logic [ERR_W-1:0] err_nxt;
    assign mis = (xor_in != (a_out ^ b_out)) | (xnor_in != ~(a_out ^ b_out));
    assign err_nxt = (mis && err_cnt != ERR_MAX) ? err_cnt + 4'd1 : err_cnt;
    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            loop_cnt <= '0;
            {a_out, b_out} <= 2'b00;
            busy <= 1'b0;
            pass <= 1'b0;
            err_cnt <= '0;
            fail_vec <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= APPLY;
                    idx <= '0;
                    loop_cnt <= '0;
                    {a_out, b_out} <= 2'b00;
                    busy <= 1'b1;
                    pass <= 1'b0;
                    err_cnt <= '0;
                    fail_vec <= '0;
                end
                APPLY, SAMPLE: if (abort) begin
                    state <= IDLE;
                    {a_out, b_out} <= 2'b00;
                    busy <= 1'b0;
                    pass <= 1'b0;
                end else if (state == APPLY) begin
                    state <= SAMPLE;
                end else begin
                    err_cnt <= err_nxt;
                    fail_vec[idx] <= fail_vec[idx] | mis;
                    if (idx != 2'(NUM_VEC - 1)) begin
                        state <= APPLY;
                        idx <= idx + 2'd1;
                        {a_out, b_out} <= idx + 2'd1;
                    end else if (loop_cnt != 3'(LOOPS - 1)) begin
                        state <= APPLY;
                        idx <= '0;
                        loop_cnt <= loop_cnt + 3'd1;
                        {a_out, b_out} <= 2'b00;
                    end else begin
                        // pass must see the final sample's result, hence err_nxt
                        state <= DONE;
                        {a_out, b_out} <= 2'b00;
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_nxt == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: time-indexed run model checks LOOPS=2 and LOOPS=5 controllers every cycle
module tb_gate_bist_ctrl;
    logic clk = 1'b0;
    logic rst, start, abort;
    int mode;
    logic a2, b2, x2, n2, busy2, done2, pass2;
    logic [3:0] err2, fv2;
    logic a5, b5, x5, n5, busy5, done5, pass5;
    logic [3:0] err5, fv5;
    int total = 0, bad = 0;
    bit chk_en = 0;
    int p [2];
    int e [2];
    logic [3:0] mfv [2];
    logic mps [2];
    int dc, dc5, bn, dn;
    logic [31:0] seq;

    always #5 clk = ~clk;

    // gate unit with selectable fault: 1 = xor stuck-at-0, 2 = xnor tied to xor
    assign x2 = (mode == 1) ? 1'b0 : a2 ^ b2;
    assign n2 = (mode == 2) ? (a2 ^ b2) : ~(a2 ^ b2);
    assign x5 = (mode == 1) ? 1'b0 : a5 ^ b5;
    assign n5 = (mode == 2) ? (a5 ^ b5) : ~(a5 ^ b5);

    gate_bist_ctrl #(.LOOPS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a_out(a2), .b_out(b2), .xor_in(x2), .xnor_in(n2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_vec(fv2)
    );

    gate_bist_ctrl #(.LOOPS(5)) dut5 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a_out(a5), .b_out(b5), .xor_in(x5), .xnor_in(n5),
        .busy(busy5), .done(done5), .pass(pass5), .err_cnt(err5), .fail_vec(fv5)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic int lp(input int d);
        return (d == 0) ? 2 : 5;
    endfunction

    function automatic bit vec_fails(input int v);
        return (mode == 2) || (mode == 1 && (v == 1 || v == 2));
    endfunction

    // p = cycles since the run was accepted: 1..8L busy, 8L+1 done, 0 idle
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                p[d] = 0; e[d] = 0; mfv[d] = 4'd0; mps[d] = 1'b0;
            end else if (p[d] == 0) begin
                if (start) begin
                    p[d] = 1; e[d] = 0; mfv[d] = 4'd0; mps[d] = 1'b0;
                end
            end else if (p[d] <= 8 * lp(d)) begin
                if (abort) begin
                    p[d] = 0; mps[d] = 1'b0;
                end else begin
                    if (p[d] % 2 == 0 && vec_fails(((p[d] - 1) / 2) % 4)) begin
                        e[d] = (e[d] < 15) ? e[d] + 1 : 15;
                        mfv[d][((p[d] - 1) / 2) % 4] = 1'b1;
                    end
                    if (p[d] == 8 * lp(d)) mps[d] = (e[d] == 0);
                    p[d]++;
                end
            end else begin
                p[d] = 0;
            end
        end
    end

    function automatic logic [12:0] model_out(input int d);
        logic bz;
        bz = (p[d] >= 1) && (p[d] <= 8 * lp(d));
        return {bz, p[d] == 8 * lp(d) + 1, bz ? 2'(((p[d] - 1) / 2) % 4) : 2'b00,
                4'(e[d]), mfv[d], mps[d]};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("l2_outs", {19'd0, busy2, done2, a2, b2, err2, fv2, pass2}, {19'd0, model_out(0)});
            chk("l5_outs", {19'd0, busy5, done5, a5, b5, err5, fv5, pass5}, {19'd0, model_out(1)});
        end
    end

    task automatic run(input int restart_at, input int abort_at, input int rst_at);
        dc = 0; dc5 = 0; bn = 0; dn = 0; seq = 0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 50; n++) begin
            start = (n == restart_at);
            abort = (n == abort_at);
            rst = (n == rst_at);
            @(negedge clk);
            if (done2 && dc == 0) dc = n;
            if (done5 && dc5 == 0) dc5 = n;
            bn += int'(busy2);
            dn += int'(done2);
            if (n <= 16) seq = {seq[29:0], a2, b2};
            if ((abort_at > 0 && n == abort_at + 1) || (rst_at > 0 && n == rst_at + 1))
                chk("idle_after_stop", {27'd0, busy2, done2, pass2, a2, b2}, 32'd0);
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
    endtask

    initial begin
        mode = 0; rst = 1'b1; start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk);
        chk("reset_state", {19'd0, busy2, done2, a2, b2, err2, fv2, pass2}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run(0, 0, 0);
        chk("ok_done_cycle", dc, 17);
        chk("ok_busy_cycles", bn, 16);
        chk("ok_stim_seq", seq, 32'h05AF05AF);
        chk("ok_l2_result", {23'd0, err2, fv2, pass2}, {23'd0, 4'd0, 4'b0000, 1'b1});
        chk("ok_l5_done_cycle", dc5, 41);
        chk("ok_l5_pass", {31'd0, pass5}, 32'd1);

        mode = 1;
        run(0, 0, 0);
        chk("xor_sa0_l2", {23'd0, err2, fv2, pass2}, {23'd0, 4'd4, 4'b0110, 1'b0});
        chk("xor_sa0_l5", {23'd0, err5, fv5, pass5}, {23'd0, 4'd10, 4'b0110, 1'b0});

        mode = 2;
        run(0, 0, 0);
        chk("xnor_tied_l2", {23'd0, err2, fv2, pass2}, {23'd0, 4'd8, 4'b1111, 1'b0});
        chk("all_fail_sat_l5", {23'd0, err5, fv5, pass5}, {23'd0, 4'd15, 4'b1111, 1'b0});

        mode = 0;
        run(3, 0, 0);
        chk("restart_ignored_done", dc, 17);
        chk("restart_ignored_pulses", dn, 1);

        mode = 2;
        run(0, 5, 0);
        chk("abort_no_done", dn + dc5, 0);
        chk("abort_partial", {24'd0, err2, fv2}, {24'd0, 4'd2, 4'b0011});

        mode = 0;
        run(0, 0, 6);
        chk("rst_no_done", dn + dc5, 0);
        chk("rst_cleared", {23'd0, err2, fv2, pass2}, 32'd0);
        run(0, 0, 0);
        chk("post_rst_done_cycle", dc, 17);
        chk("post_rst_pass", {31'd0, pass2}, 32'd1);
        chk("post_rst_seq", seq, 32'h05AF05AF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
